inst_align_queue: RTL and testbench



---
 rtl/inst_align_queue.sv | 127 ++++++++++++
 tb/tb_inst_align_queue.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_align_queue.sv
// Halfword FIFO between fetch and decode that re-aligns mixed 16/32-bit instructions.
// Latency: a beat accepted in cycle N can appear at the head in cycle N+1. Nothing bypasses storage.
// Backpressure: fetch_ready is high only while a whole beat fits. decode stalls with inst_ready=0.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   flush, flush_pc      redirect: empty the queue and restart at flush_pc (bit 0 ignored)
//   fetch_valid/_ready   beat handshake. fetch_data holds little-endian halfwords
//   inst_valid/_ready    decode handshake. inst, inst_pc and compressed are zero when not valid
//   count                occupied halfwords
module inst_align_queue #(
  parameter int FETCH_W  = 64,
  parameter int DEPTH_HW = 16,
  parameter int PC_W     = 64
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
  input  logic [PC_W-1:0]             flush_pc,
  input  logic                        fetch_valid,
  output logic                        fetch_ready,
  input  logic [FETCH_W-1:0]          fetch_data,
  output logic                        inst_valid,
  input  logic                        inst_ready,
  output logic [31:0]                 inst,
  output logic [PC_W-1:0]             inst_pc,
  output logic                        compressed,
  output logic [$clog2(DEPTH_HW):0]   count
);

  localparam int BEAT_HW = FETCH_W / 16;
  localparam int PTR_W   = $clog2(DEPTH_HW);
  localparam int CNT_W   = PTR_W + 1;
  // The skip field covers halfword offsets within one beat.
  localparam int SKIP_W  = $clog2(FETCH_W / 8) - 1;

  logic [15:0]       mem_q [DEPTH_HW];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [PC_W-1:0]   head_pc_q, head_pc_d;
  logic [SKIP_W-1:0] skip_q, skip_d;

  logic [15:0]       h0, h1;
  logic              is_rvc;
  logic              push, pop;
  logic [CNT_W-1:0]  push_n, pop_n;

  // Bit 0 of the redirect target is not meaningful for halfword-aligned code.
  logic unused_flush_pc0;
  assign unused_flush_pc0 = flush_pc[0];

  // Head decode straight from storage. h1 wraps so a split 32-bit instruction reassembles.
  assign h0     = mem_q[rd_ptr_q];
  assign h1     = mem_q[rd_ptr_q + PTR_W'(1)];
  assign is_rvc = (h0[1:0] != 2'b11);

  assign inst_valid = is_rvc ? (count_q != '0) : (count_q >= CNT_W'(2));
  assign compressed = inst_valid & is_rvc;
  assign inst       = !inst_valid ? 32'h0 : (is_rvc ? {16'h0, h0} : {h1, h0});
  assign inst_pc    = inst_valid ? head_pc_q : '0;
  assign count      = count_q;

  // Ready depends on pre-pop occupancy only. This never lets a beat be partially written.
  assign fetch_ready = (CNT_W'(DEPTH_HW) - count_q) >= CNT_W'(BEAT_HW);

  assign push   = fetch_valid & fetch_ready;
  assign pop    = inst_valid & inst_ready;
  assign push_n = push ? (CNT_W'(BEAT_HW) - CNT_W'(skip_q)) : '0;
  assign pop_n  = !pop ? '0 : (is_rvc ? CNT_W'(1) : CNT_W'(2));

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    head_pc_d = head_pc_q;
    skip_d    = skip_q;
    if (flush) begin
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      count_d   = '0;
      head_pc_d = {flush_pc[PC_W-1:1], 1'b0};
      // The first beat after a redirect starts at the aligned beat address.
      // Halfwords below the target must be dropped.
      skip_d    = flush_pc[SKIP_W:1];
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(push_n);
        skip_d   = '0;
      end
      if (pop) begin
        rd_ptr_d  = rd_ptr_q + PTR_W'(pop_n);
        head_pc_d = head_pc_q + (is_rvc ? PC_W'(2) : PC_W'(4));
      end
      count_d = count_q + push_n - pop_n;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      head_pc_q <= '0;
      skip_q    <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      head_pc_q <= head_pc_d;
      skip_q    <= skip_d;
    end
  end

  // Storage needs no reset. Every read is qualified by count.
  // Surviving halfword i of the beat lands at wr_ptr + i - skip.
  always_ff @(posedge clk) begin
    if (!rst && !flush && push) begin
      for (int i = 0; i < BEAT_HW; i++) begin
        if (i >= int'(skip_q)) begin
          mem_q[wr_ptr_q + PTR_W'(i) - PTR_W'(skip_q)] <= fetch_data[16*i +: 16];
        end
      end
    end
  end

endmodule

// File: tb/tb_inst_align_queue.sv
module tb_inst_align_queue;
  localparam int FETCH_W  = 64;
  localparam int DEPTH_HW = 16;
  localparam int PC_W     = 64;

  logic               clk = 1'b0;
  logic               rst, flush, fetch_valid, fetch_ready, inst_valid, inst_ready, compressed;
  logic [PC_W-1:0]    flush_pc, inst_pc;
  logic [FETCH_W-1:0] fetch_data;
  logic [31:0]        inst;
  logic [4:0]         count;

  int vectors = 0;
  int miscompares = 0;

  // The observation vector is {fetch_ready, inst_valid, compressed, count, inst, inst_pc}.
  wire  [103:0] obs = {fetch_ready, inst_valid, compressed, count, inst, inst_pc};
  logic [103:0] exp_v;
  localparam logic [103:0] IDLE = {1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 64'h0};

  always #5 clk = ~clk;

  inst_align_queue #(.FETCH_W(FETCH_W), .DEPTH_HW(DEPTH_HW), .PC_W(PC_W)) dut (
    .clk(clk), .rst(rst), .flush(flush), .flush_pc(flush_pc),
    .fetch_valid(fetch_valid), .fetch_ready(fetch_ready), .fetch_data(fetch_data),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst),
    .inst_pc(inst_pc), .compressed(compressed), .count(count)
  );

  // Inputs change and outputs are sampled at negedge. State moves at posedge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [31:0] wrap_inst(int k);
    return {16'h1000 + 16'(k), 16'h0013 + 16'(k << 8)};
  endfunction

  // The stream starts at 0x1002 with c.nop, followed by 32-bit wrap_inst(k) at 0x1004+4k.
  function automatic logic [63:0] wrap_beat(int b);
    if (b == 1) return {wrap_inst(0), 16'h0001, 16'hDEAD};
    if (b > 6)  return 64'h0;
    return {wrap_inst(2*b-2), wrap_inst(2*b-3)};
  endfunction

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; flush_pc = '0; fetch_valid = 1'b0;
    fetch_data = '0; inst_ready = 1'b0;
    step(); step();
    if (obs !== IDLE) begin
      $display("FAIL reset_state got %h want %h", obs, IDLE); miscompares++;
    end
    vectors++;
    rst = 1'b0;
  endtask

  task automatic test_basic();
    flush = 1'b1; flush_pc = 64'h8000_0000; step(); flush = 1'b0;
    if (obs !== IDLE) begin
      $display("FAIL basic_after_flush got %h want %h", obs, IDLE); miscompares++;
    end
    vectors++;
    fetch_valid = 1'b1; fetch_data = 64'h00000013_00000013; step(); fetch_valid = 1'b0;
    exp_v = {1'b1, 1'b1, 1'b0, 5'd4, 32'h00000013, 64'h8000_0000};
    if (obs !== exp_v) begin
      $display("FAIL basic_first got %h want %h", obs, exp_v); miscompares++;
    end
    vectors++;
    inst_ready = 1'b1; step();
    exp_v = {1'b1, 1'b1, 1'b0, 5'd2, 32'h00000013, 64'h8000_0004};
    if (obs !== exp_v) begin
      $display("FAIL basic_second got %h want %h", obs, exp_v); miscompares++;
    end
    vectors++;
    step();
    if (obs !== IDLE) begin
      $display("FAIL basic_drained got %h want %h", obs, IDLE); miscompares++;
    end
    vectors++;
    inst_ready = 1'b0;
  endtask

  task automatic test_mixed();
    fetch_valid = 1'b1; fetch_data = 64'h0001_0000_0013_4501; step(); fetch_valid = 1'b0;
    exp_v = {1'b1, 1'b1, 1'b1, 5'd4, 32'h00004501, 64'h8000_0008};
    if (obs !== exp_v) begin
      $display("FAIL mixed_rvc0 got %h want %h", obs, exp_v); miscompares++;
    end
    vectors++;
    inst_ready = 1'b1; step();
    exp_v = {1'b1, 1'b1, 1'b0, 5'd3, 32'h00000013, 64'h8000_000A};
    if (obs !== exp_v) begin
      $display("FAIL mixed_rv32 got %h want %h", obs, exp_v); miscompares++;
    end
    vectors++;
    step();
    exp_v = {1'b1, 1'b1, 1'b1, 5'd1, 32'h00000001, 64'h8000_000E};
    if (obs !== exp_v) begin
      $display("FAIL mixed_rvc1 got %h want %h", obs, exp_v); miscompares++;
    end
    vectors++;
    step();
    if (obs !== IDLE) begin
      $display("FAIL mixed_drained got %h want %h", obs, IDLE); miscompares++;
    end
    vectors++;
    inst_ready = 1'b0;
  endtask

  task automatic test_straddle();
    fetch_valid = 1'b1; fetch_data = 64'h0513_0001_0001_0001; inst_ready = 1'b1;
    step(); fetch_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      exp_v = {1'b1, 1'b1, 1'b1, 5'(4 - i), 32'h00000001, 64'h8000_0010 + 64'(2 * i)};
      if (obs !== exp_v) begin
        $display("FAIL straddle_rvc%0d got %h want %h", i, obs, exp_v); miscompares++;
      end
      vectors++;
      step();
    end
    // Only the low half of 0x00000513 is stored, so no instruction may be shown yet.
    for (int i = 0; i < 2; i++) begin
      exp_v = {1'b1, 1'b0, 1'b0, 5'd1, 32'h0, 64'h0};
      if (obs !== exp_v) begin
        $display("FAIL straddle_wait%0d got %h want %h", i, obs, exp_v); miscompares++;
      end
      vectors++;
      if (i == 0) step();
    end
    fetch_valid = 1'b1; fetch_data = 64'h0001_0001_0001_0000; step(); fetch_valid = 1'b0;
    exp_v = {1'b1, 1'b1, 1'b0, 5'd5, 32'h00000513, 64'h8000_0016};
    if (obs !== exp_v) begin
      $display("FAIL straddle_join got %h want %h", obs, exp_v); miscompares++;
    end
    vectors++;
    step();
    exp_v = {1'b1, 1'b1, 1'b1, 5'd3, 32'h00000001, 64'h8000_001A};
    if (obs !== exp_v) begin
      $display("FAIL straddle_after got %h want %h", obs, exp_v); miscompares++;
    end
    vectors++;
    step(); step(); step();
    if (obs !== IDLE) begin
      $display("FAIL straddle_drained got %h want %h", obs, IDLE); miscompares++;
    end
    vectors++;
    inst_ready = 1'b0;
  endtask

  task automatic test_flush_skip();
    flush = 1'b1; flush_pc = 64'h8000_0006; step(); flush = 1'b0;
    if (obs !== IDLE) begin
      $display("FAIL skip_after_flush got %h want %h", obs, IDLE); miscompares++;
    end
    vectors++;
    fetch_valid = 1'b1; fetch_data = 64'h0001_AAAA_BBBB_CCCC; step(); fetch_valid = 1'b0;
    exp_v = {1'b1, 1'b1, 1'b1, 5'd1, 32'h00000001, 64'h8000_0006};
    if (obs !== exp_v) begin
      $display("FAIL skip_first got %h want %h", obs, exp_v); miscompares++;
    end
    vectors++;
    // Push a full beat while popping. The skip must already be cleared.
    fetch_valid = 1'b1; fetch_data = 64'h0001_0001_0001_0001; inst_ready = 1'b1;
    step(); fetch_valid = 1'b0; inst_ready = 1'b0;
    exp_v = {1'b1, 1'b1, 1'b1, 5'd4, 32'h00000001, 64'h8000_0008};
    if (obs !== exp_v) begin
      $display("FAIL skip_push_pop got %h want %h", obs, exp_v); miscompares++;
    end
    vectors++;
    inst_ready = 1'b1; step(); step(); step(); step(); inst_ready = 1'b0;
    if (obs !== IDLE) begin
      $display("FAIL skip_drained got %h want %h", obs, IDLE); miscompares++;
    end
    vectors++;
  endtask

  task automatic test_full_wrap();
    int b;
    int idx;
    logic acc, pop;
    logic [96:0] want_i;
    // Bit 0 of the target is ignored, giving head_pc 0x1002 and a skip of 1.
    flush = 1'b1; flush_pc = 64'h1003; step(); flush = 1'b0;
    b = 1; idx = 0; inst_ready = 1'b0;
    fetch_valid = 1'b1; fetch_data = wrap_beat(1);
    for (int cyc = 0; cyc < 80; cyc++) begin
      if (cyc == 8) begin
        exp_v = {1'b0, 1'b1, 1'b1, 5'd15, 32'h00000001, 64'h1002};
        if (obs !== exp_v || b != 5) begin
          $display("FAIL wrap_stalled got %h beat %0d want %h beat 5", obs, b, exp_v);
          miscompares++;
        end
        vectors++;
        inst_ready = 1'b1;
      end
      if (cyc >= 8 && idx == 12 && b == 7) break;
      acc = fetch_valid & fetch_ready;
      pop = inst_valid & inst_ready;
      if (fetch_ready !== (count <= 5'd12)) begin
        $display("FAIL wrap_ready got %b want %b count %0d", fetch_ready, (count <= 5'd12), count);
        miscompares++;
      end
      vectors++;
      if (pop) begin
        if (idx == 0) want_i = {1'b1, 32'h00000001, 64'h1002};
        else          want_i = {1'b0, wrap_inst(idx - 1), 64'h1004 + 64'(4 * (idx - 1))};
        if (idx >= 12 || {compressed, inst, inst_pc} !== want_i) begin
          $display("FAIL wrap_pop%0d got %h want %h", idx, {compressed, inst, inst_pc}, want_i);
          miscompares++;
        end
        vectors++;
        idx++;
      end
      step();
      if (acc) b++;
      fetch_valid = (b <= 6);
      fetch_data = wrap_beat(b);
    end
    if (idx != 12 || b != 7 || obs !== IDLE) begin
      $display("FAIL wrap_end got pops %0d beat %0d obs %h want pops 12 beat 7 obs %h",
               idx, b, obs, IDLE);
      miscompares++;
    end
    vectors++;
    inst_ready = 1'b0; fetch_valid = 1'b0;
  endtask

  task automatic test_flush_collision();
    flush = 1'b1; flush_pc = 64'h2000; step(); flush = 1'b0;
    fetch_valid = 1'b1; fetch_data = 64'h0001_0001_0001_0001; step(); fetch_valid = 1'b0;
    exp_v = {1'b1, 1'b1, 1'b1, 5'd4, 32'h00000001, 64'h2000};
    if (obs !== exp_v) begin
      $display("FAIL coll_setup got %h want %h", obs, exp_v); miscompares++;
    end
    vectors++;
    flush = 1'b1; flush_pc = 64'h3000; fetch_valid = 1'b1; inst_ready = 1'b1;
    step(); flush = 1'b0; fetch_valid = 1'b0; inst_ready = 1'b0;
    if (obs !== IDLE) begin
      $display("FAIL coll_flushed got %h want %h", obs, IDLE); miscompares++;
    end
    vectors++;
    fetch_valid = 1'b1; step(); fetch_valid = 1'b0;
    exp_v = {1'b1, 1'b1, 1'b1, 5'd4, 32'h00000001, 64'h3000};
    if (obs !== exp_v) begin
      $display("FAIL coll_refill got %h want %h", obs, exp_v); miscompares++;
    end
    vectors++;
  endtask

  task automatic test_reset_traffic();
    rst = 1'b1; flush = 1'b1; flush_pc = 64'h4000; fetch_valid = 1'b1; inst_ready = 1'b1;
    step();
    if (obs !== IDLE) begin
      $display("FAIL rst_traffic got %h want %h", obs, IDLE); miscompares++;
    end
    vectors++;
    rst = 1'b0; flush = 1'b0; inst_ready = 1'b0;
    step(); fetch_valid = 1'b0;
    exp_v = {1'b1, 1'b1, 1'b1, 5'd4, 32'h00000001, 64'h0};
    if (obs !== exp_v) begin
      $display("FAIL rst_refill got %h want %h", obs, exp_v); miscompares++;
    end
    vectors++;
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_basic();
    test_mixed();
    test_straddle();
    test_flush_skip();
    test_full_wrap();
    test_flush_collision();
    test_reset_traffic();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
